// File: rtl/dav_phase_align.sv
// dav_phase_align: DAV receive-path training controller.
//
// Walks the four select settings of every per-channel DAV synchronizer. At each setting it
// runs NTRIAL trials. A trial is one MARK followed by a check that the synchronizer output
// is 0,1,0 at LAT-1, LAT and LAT+1 cycles after the MARK. A channel locks to the first
// setting at which every trial passes. Synchronizer enables are masked (KILL) while
// training runs.
//
// Ports
//   C        in   clock, rising edge
//   RST      in   asynchronous active-high reset
//   START    in   one-cycle pulse; begins a run (ignored while BUSY)
//   MARK     in   one-cycle pulse; the remote side is emitting one training pulse
//   Q        in   [NCH]   synchronizer outputs
//   KILL_IN  in   external mask request
//   S        out  [2*NCH] per-channel select, S[2i+1:2i] for channel i
//   KILL     out  BUSY | KILL_IN (combinational)
//   BUSY     out  run in progress
//   DONE     out  run finished; held until the next START or reset
//   LOCKED   out  [NCH]   channel found a passing setting
//   TIMEOUT  out  run ended because no MARK arrived within TMO cycles
module dav_phase_align #(
  parameter int unsigned NCH    = 4,
  parameter int unsigned LAT    = 4,     // must be >= 2
  parameter int unsigned NTRIAL = 8,
  parameter int unsigned SETTLE = 4,     // must be >= 1
  parameter int unsigned TMO    = 1023
) (
  input  logic             C,
  input  logic             RST,
  input  logic             START,
  input  logic             MARK,
  input  logic [NCH-1:0]   Q,
  input  logic             KILL_IN,
  output logic [2*NCH-1:0] S,
  output logic             KILL,
  output logic             BUSY,
  output logic             DONE,
  output logic [NCH-1:0]   LOCKED,
  output logic             TIMEOUT
);

  localparam int unsigned DW = $clog2(LAT + 2);
  localparam int unsigned TW = $clog2(NTRIAL + 1);
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned OW = $clog2(TMO + 1);

  localparam logic [DW-1:0] DPre  = DW'(LAT - 1);
  localparam logic [DW-1:0] DHit  = DW'(LAT);
  localparam logic [DW-1:0] DPost = DW'(LAT + 1);
  localparam logic [TW-1:0] TLast = TW'(NTRIAL - 1);
  localparam logic [SW-1:0] SLast = SW'(SETTLE - 1);
  localparam logic [OW-1:0] OLast = OW'(TMO - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StWaitMark,
    StCheck,
    StNext,
    StFinish
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         k_q, k_d;            // select currently being scanned
  logic [TW-1:0]      t_q, t_d;            // trials completed at this select
  logic [DW-1:0]      d_q, d_d;            // cycles since the MARK edge
  logic [SW-1:0]      scnt_q, scnt_d;      // settle counter
  logic [OW-1:0]      tmo_q, tmo_d;        // cycles spent waiting for MARK
  logic [NCH-1:0]     good_q, good_d;      // no failed trial yet at this select
  logic [NCH-1:0]     locked_q, locked_d;
  logic [2*NCH-1:0]   sel_q, sel_d;        // latched setting, valid where locked
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic [NCH-1:0]     new_lock;
  logic               busy;

  always_ff @(posedge C or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      k_q       <= '0;
      t_q       <= '0;
      d_q       <= '0;
      scnt_q    <= '0;
      tmo_q     <= '0;
      good_q    <= '0;
      locked_q  <= '0;
      sel_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      t_q       <= t_d;
      d_q       <= d_d;
      scnt_q    <= scnt_d;
      tmo_q     <= tmo_d;
      good_q    <= good_d;
      locked_q  <= locked_d;
      sel_q     <= sel_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    t_d       = t_q;
    d_d       = d_q;
    scnt_d    = scnt_q;
    tmo_d     = tmo_q;
    good_d    = good_q;
    locked_d  = locked_q;
    sel_d     = sel_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    new_lock  = ~locked_q & good_q;

    unique case (state_q)
      StIdle: begin
        if (START) begin
          done_d    = 1'b0;
          locked_d  = '0;
          sel_d     = '0;
          timeout_d = 1'b0;
          k_d       = 2'd0;
          t_d       = '0;
          good_d    = '1;
          scnt_d    = '0;
          state_d   = StSettle;
        end
      end

      StSettle: begin
        if (scnt_q == SLast) begin
          tmo_d   = '0;
          state_d = StWaitMark;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end

      StWaitMark: begin
        // A MARK on the final allowed cycle still counts.
        if (MARK) begin
          d_d     = '0;
          state_d = StCheck;
        end else if (tmo_q == OLast) begin
          timeout_d = 1'b1;
          state_d   = StFinish;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      StCheck: begin
        // MARK is not looked at here, so extra marks are dropped.
        d_d = d_q + 1'b1;
        if (d_q == DPre) begin
          good_d = good_q & ~Q;
        end else if (d_q == DHit) begin
          good_d = good_q & Q;
        end else if (d_q == DPost) begin
          good_d = good_q & ~Q;
          d_d    = d_q;
          t_d    = t_q + 1'b1;
          tmo_d  = '0;
          state_d = (t_q == TLast) ? StNext : StWaitMark;
        end
      end

      StNext: begin
        locked_d = locked_q | new_lock;
        for (int unsigned i = 0; i < NCH; i++) begin
          if (new_lock[i]) begin
            sel_d[2*i +: 2] = k_q;
          end
        end
        if ((&locked_d) || (k_q == 2'd3)) begin
          state_d = StFinish;
        end else begin
          k_d     = k_q + 2'd1;
          t_d     = '0;
          good_d  = '1;
          scnt_d  = '0;
          state_d = StSettle;
        end
      end

      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

  // Locked channels hold their setting; the rest follow the scan, then park at 0.
  always_comb begin
    S = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (locked_q[i]) begin
        S[2*i +: 2] = sel_q[2*i +: 2];
      end else if (busy) begin
        S[2*i +: 2] = k_q;
      end
    end
  end

  assign KILL    = busy | KILL_IN;
  assign BUSY    = busy;
  assign DONE    = done_q;
  assign LOCKED  = locked_q;
  assign TIMEOUT = timeout_q;

endmodule

// File: tb/tb_dav_phase_align.sv
// Bench for dav_phase_align: randomized runs against a timeline model of the training
// sequence, with a behavioural synchronizer bank driving Q and a scoreboard checked at DONE.
module tb_dav_phase_align;

  localparam int NCH    = 4;
  localparam int LAT    = 4;
  localparam int NTRIAL = 8;
  localparam int SETTLE = 4;
  localparam int TMO    = 1023;

  logic             C = 1'b0;
  logic             RST = 1'b1;
  logic             START = 1'b0;
  logic             MARK = 1'b0;
  logic [NCH-1:0]   Q = '0;
  logic             KILL_IN = 1'b0;
  logic [2*NCH-1:0] S;
  logic             KILL, BUSY, DONE, TIMEOUT;
  logic [NCH-1:0]   LOCKED;

  dav_phase_align #(
    .NCH(NCH), .LAT(LAT), .NTRIAL(NTRIAL), .SETTLE(SETTLE), .TMO(TMO)
  ) dut (
    .C(C), .RST(RST), .START(START), .MARK(MARK), .Q(Q), .KILL_IN(KILL_IN),
    .S(S), .KILL(KILL), .BUSY(BUSY), .DONE(DONE), .LOCKED(LOCKED), .TIMEOUT(TIMEOUT)
  );

  always #5 C = ~C;

  typedef struct {
    logic [NCH-1:0]   locked;
    logic [2*NCH-1:0] s;
    logic             timeout;
    longint           done_edge;
  } exp_t;

  exp_t   exp_q[$];
  int     n_tests = 0;
  int     n_fail = 0;
  longint cyc = 0;

  // Run configuration shared by stimulus, mark driver and synchronizer model.
  int     corr[NCH];        // select at which channel is correctly phased, 4 = never
  int     drop_k[NCH];      // select index at which one pulse is dropped, -1 = none
  int     drop_t[NCH];
  int     per = 10;
  int     off = 3;
  bit     marks_en = 1'b1;
  bit     run_active = 1'b0;
  bit     kill_rand = 1'b0;
  longint st_edge = 0;
  longint extra_edge = -1;
  longint cons_edge[4][NTRIAL];   // edge at which each trial's MARK is accepted
  logic [15:0] pend[NCH];

  always @(posedge C) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic longint next_mark(longint w);
    longint b, j;
    if (!marks_en) return -1;
    b = st_edge + off;
    if (w + 1 <= b) return b;
    j = (w + 1 - b + per - 1) / per;
    return b + j * per;
  endfunction

  // Timeline of a run: when each trial's mark is taken, what locks, when DONE rises.
  task automatic model_run(output exp_t ex);
    longint w, e;
    logic [NCH-1:0] lk;
    for (int k = 0; k < 4; k++)
      for (int t = 0; t < NTRIAL; t++) cons_edge[k][t] = -1;
    lk = '0;
    ex.s = '0;
    ex.timeout = 1'b0;
    ex.done_edge = -1;
    w = st_edge + SETTLE;
    for (int k = 0; k < 4 && ex.done_edge < 0; k++) begin
      for (int t = 0; t < NTRIAL && ex.done_edge < 0; t++) begin
        e = next_mark(w);
        if (e < 0 || e > w + TMO) begin
          ex.timeout = 1'b1;
          ex.done_edge = w + TMO + 1;
        end else begin
          cons_edge[k][t] = e;
          w = e + LAT + 2;
        end
      end
      if (ex.done_edge < 0) begin
        for (int i = 0; i < NCH; i++) begin
          if (!lk[i] && corr[i] == k && drop_k[i] != k) begin
            lk[i] = 1'b1;
            ex.s[2*i +: 2] = 2'(k);
          end
        end
        if ((&lk) || k == 3) ex.done_edge = w + 2;
        else w = w + 1 + SETTLE;
      end
    end
    ex.locked = lk;
  endtask

  // Pulse delay (cycles after the MARK) produced by channel i at select sel; -1 = no pulse.
  function automatic int syn_delay(int i, logic [1:0] sel, longint m);
    for (int k = 0; k < 4; k++)
      for (int t = 0; t < NTRIAL; t++)
        if (cons_edge[k][t] == m && drop_k[i] == k && drop_t[i] == t) return -1;
    if (corr[i] > 3) return LAT + 1;
    return LAT + int'(sel) - corr[i];
  endfunction

  // Synchronizer bank model.
  initial begin
    int dl;
    for (int i = 0; i < NCH; i++) pend[i] = '0;
    forever begin
      @(negedge C);
      if (RST) begin
        for (int i = 0; i < NCH; i++) pend[i] = '0;
        Q = '0;
      end else begin
        for (int i = 0; i < NCH; i++) begin
          Q[i] = pend[i][0];
          pend[i] = pend[i] >> 1;
          if (MARK) begin
            dl = syn_delay(i, S[2*i +: 2], cyc + 1);
            if (dl >= 0 && dl < 16) pend[i][dl] = 1'b1;
          end
        end
      end
    end
  end

  // Mark driver: periodic marks from the run's start, plus an optional stray one.
  initial begin
    longint rel;
    forever begin
      @(posedge C);
      #2;
      MARK = 1'b0;
      if (run_active) begin
        rel = cyc + 1 - st_edge - off;
        if (marks_en && rel >= 0 && (rel % per) == 0) MARK = 1'b1;
        if (cyc + 1 == extra_edge) MARK = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge C);
      #3;
      KILL_IN = kill_rand ? 1'($urandom) : 1'b0;
    end
  end

  // Monitor: KILL every cycle, scoreboard pop on each DONE rise.
  initial begin
    exp_t ex;
    logic dp;
    dp = 1'b0;
    forever begin
      @(negedge C);
      check("kill", KILL, BUSY | KILL_IN);
      if (RST) begin
        dp = 1'b0;
      end else begin
        if (DONE && !dp) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1'b1, 1'b0);
          end else begin
            ex = exp_q.pop_front();
            check("locked", LOCKED, ex.locked);
            check("sel", S, ex.s);
            check("timeout", TIMEOUT, ex.timeout);
            check("busy_end", BUSY, 1'b0);
            check("done_edge", cyc, ex.done_edge);
          end
        end
        dp = DONE;
      end
    end
  end

  task automatic start_run();
    exp_t ex;
    @(posedge C);
    #1;
    st_edge = cyc + 1;
    extra_edge = -1;
    model_run(ex);
    exp_q.push_back(ex);
    START = 1'b1;
    run_active = 1'b1;
    @(posedge C);
    #1;
    START = 1'b0;
    check("busy_rise", BUSY, 1'b1);
    check("done_clr", DONE, 1'b0);
    check("locked_clr", LOCKED, '0);
  endtask

  task automatic wait_done(string name);
    int n;
    n = 0;
    while (!DONE && n < 5000) begin
      @(negedge C);
      n++;
    end
    if (!DONE) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: DONE not seen within 5000 cycles", name);
    end
    repeat (3) @(negedge C);
    run_active = 1'b0;
    repeat (10) @(posedge C);
  endtask

  task automatic check_reset_vals(string name);
    check({name, "_s"}, S, '0);
    check({name, "_busy"}, BUSY, 1'b0);
    check({name, "_done"}, DONE, 1'b0);
    check({name, "_locked"}, LOCKED, '0);
    check({name, "_timeout"}, TIMEOUT, 1'b0);
    check({name, "_kill"}, KILL, KILL_IN);
  endtask

  task automatic rand_cfg(bit drops);
    per = int'($urandom_range(12, 8));
    off = int'($urandom_range(per, 1));
    for (int i = 0; i < NCH; i++) begin
      corr[i] = int'($urandom_range(4, 0));
      drop_k[i] = (drops && $urandom_range(1, 0) == 1) ? int'($urandom_range(3, 0)) : -1;
      drop_t[i] = int'($urandom_range(NTRIAL - 1, 0));
    end
  endtask

  initial begin
    int n;
    corr = '{4, 4, 4, 4};
    drop_k = '{-1, -1, -1, -1};
    drop_t = '{0, 0, 0, 0};
    repeat (3) @(posedge C);
    #1;
    check_reset_vals("reset");
    RST = 1'b0;
    repeat (2) @(posedge C);

    // Every channel phased at select 2: three selects scanned, 24 marks taken.
    corr = '{2, 2, 2, 2};
    per = 10;
    off = 3;
    start_run();
    wait_done("lock_at_2");

    // Mixed channels, plus a stray MARK in CHECK and a START while busy.
    corr = '{0, 3, 1, 4};
    per = int'($urandom_range(12, 8));
    off = int'($urandom_range(per, 1));
    start_run();
    extra_edge = cons_edge[0][1] + 2;
    repeat (30) @(posedge C);
    #1;
    check("busy_mid", BUSY, 1'b1);
    START = 1'b1;
    @(posedge C);
    #1;
    START = 1'b0;
    wait_done("mixed");

    // Channel 0 correct only at select 0 but loses one pulse there.
    rand_cfg(1'b0);
    corr[0] = 0;
    drop_k[0] = 0;
    drop_t[0] = 5;
    start_run();
    wait_done("bad_trial");
    drop_k[0] = -1;

    // No marks at all.
    marks_en = 1'b0;
    start_run();
    wait_done("timeout");
    marks_en = 1'b1;

    // Reset while checking a trial at select 1.
    corr = '{0, 2, 2, 2};
    per = 10;
    off = 2;
    start_run();
    n = 0;
    while (cyc < cons_edge[1][0] + 2 && n < 2000) begin
      @(posedge C);
      #1;
      n++;
    end
    check("pre_rst_locked", LOCKED, 4'b0001);
    check("pre_rst_sel", S, 8'b01_01_01_00);
    check("pre_rst_busy", BUSY, 1'b1);
    #2;
    RST = 1'b1;
    #1;
    check_reset_vals("async_rst");
    run_active = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge C);
    #1;
    RST = 1'b0;
    rand_cfg(1'b0);
    start_run();
    wait_done("after_rst");

    // Random configurations with random KILL_IN and dropped pulses.
    kill_rand = 1'b1;
    for (int r = 0; r < 6; r++) begin
      rand_cfg(1'b1);
      start_run();
      wait_done("random");
    end
    kill_rand = 1'b0;

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dav_phase_align.md
# dav_phase_align

Training controller for the DAV receive path: scans the four phase/delay settings of each per-channel DAV synchronizer/mux against a known training pulse and locks each channel to the first setting that delivers the pulse on the expected cycle. Sits between the local readout sequencer (which issues training marks) and the bank of DAV synchronizers. It drives their `S[1:0]` selects and gates their enable outputs while training.

## Interface
- `NCH`, 4: number of DAV channels.
- `LAT`, 4: expected cycles from `MARK` to the DAV pulse at a correctly phased synchronizer output. Legal range is ≥2.
- `NTRIAL`, 8: trials per setting. All must be good for a pass.
- `SETTLE`, 4: idle cycles after any select change before trials start.
- `TMO`, 1023: maximum cycles to wait for a `MARK`.

- `C` in, 1: clock. All logic is on the rising edge.
- `RST` in, 1: asynchronous, active-high reset.
- `START` in, 1: single-cycle pulse that begins a training run.
- `MARK` in, 1: single-cycle pulse issued when the remote FPGA is commanded to emit one DAV training pulse.
- `Q` in, NCH: synchronizer outputs, one bit per channel.
- `KILL_IN` in, 1: external mask request.
- `S` out, 2*NCH: `S[2i+1:2i]` is the select for channel i.
- `KILL` out, 1: equals `BUSY | KILL_IN`. Combinational.
- `BUSY` out, 1: training in progress.
- `DONE` out, 1: high from the end of a run until the next `START` or reset.
- `LOCKED` out, NCH: channel found a passing setting.
- `TIMEOUT` out, 1: the run ended on a `MARK` timeout.

## Operation
- **Reset values:** state is IDLE. `S`=0, `BUSY`=0, `DONE`=0, `LOCKED`=0, `TIMEOUT`=0. `KILL` follows `KILL_IN`.
- **States:** IDLE, SETTLE, WAIT_MARK, CHECK, NEXT, FINISH.
- **IDLE:**
  - On `START`, clear `DONE`, `LOCKED` and `TIMEOUT`.
  - Set scan index `k`=0 and trial count `t`=0.
  - Set per-channel `good[i]`=1.
  - Go to SETTLE.
- **S drive:**
  - A channel with `LOCKED[i]`=1 outputs its latched setting.
  - An unlocked channel outputs `k` while BUSY.
  - An unlocked channel outputs 0 once the run ends.
- **SETTLE:** count `SETTLE` cycles, then go to WAIT_MARK.
- **WAIT_MARK:**
  - On `MARK`, go to CHECK with the delay counter `d`=0.
  - If `TMO` cycles pass without `MARK`, set `TIMEOUT` and go to FINISH.
- **CHECK:**
  - `d` increments each cycle.
  - Q is sampled at `d`=LAT-1, LAT and LAT+1.
  - A trial is good for channel i iff those three samples of `Q[i]` are 0, 1, 0. Otherwise clear `good[i]`.
  - `MARK` is ignored while in CHECK.
  - After the `d`=LAT+1 sample, increment `t`.
  - If `t`<NTRIAL, go to WAIT_MARK. Else go to NEXT.
- **NEXT:**
  - For each unlocked i with `good[i]`=1: set `LOCKED[i]` and latch `k` as its setting.
  - If all channels are locked, or `k`=3, go to FINISH.
  - Else increment `k`, set `t`=0, set `good`=all 1, and go to SETTLE.
- **FINISH:** set `DONE` and clear `BUSY`, then return to IDLE.
- **Simultaneous events and reset:**
  - `START` while BUSY is ignored.
  - `RST` mid-run returns everything to reset values immediately.
  - `START` and `MARK` in the same cycle: the `MARK` is ignored.
- **Counter widths:**
  - `d` holds LAT+1.
  - `t` holds NTRIAL.
  - The timeout counter holds TMO.
  - `k` is 2 bits and never wraps; the scan ends at 3.

## Timing
- `BUSY` rises the cycle after `START` is sampled.
- `S` takes the new `k` on the same edge the state enters SETTLE.
- A trial occupies LAT+2 cycles from the `MARK` edge to the exit from CHECK.
- Minimum run for all channels locked at `k`=0: 1 + SETTLE + NTRIAL·(LAT+2) + 1 cycles, plus gaps between marks.
- `DONE` and `BUSY`=0 change on the same edge.
- `LOCKED` bits update on the NEXT-cycle edge.
- `KILL` has zero latency from `BUSY`/`KILL_IN`.

## Test plan
- **Lock at setting 2:**
  - Stimulus: NCH=1, behavioural synchronizer model whose DAV pulse meets the LAT=4 expectation only at select 2, marks every 10 cycles.
  - Required response: `LOCKED`=1, `S`=2, `DONE`=1, `TIMEOUT`=0, exactly 24 marks consumed.
- **Mixed channels:**
  - Stimulus: channels 0–3 correct at selects 0, 3, 1 and never.
  - Required response: `LOCKED`=4'b0111, `S`=8'b00_01_11_00, run ends after k=3.
- **Single bad trial:**
  - Stimulus: channel correct at select 0, but its pulse is dropped on trial 5.
  - Required response: no lock at 0; lock at the next correct setting, or unlocked with `S`=0.
- **Timeout:**
  - Stimulus: no `MARK` after `START`.
  - Required response: `TIMEOUT`=1 and `DONE`=1 at TMO+SETTLE+2 cycles, `LOCKED`=0.
- **Reset mid-run:**
  - Stimulus: assert `RST` during CHECK.
  - Required response: all outputs at reset values asynchronously; a subsequent `START` runs normally.
- **KILL and ignored inputs:**
  - Stimulus: `KILL_IN`=0 throughout; pulse `START` during BUSY; pulse `MARK` during CHECK.
  - Required response: `KILL`=`BUSY` throughout; the extra `START` and `MARK` have no effect.
